// File: rtl/pipelined_mdu.sv
// Iterative RV32M multiply/divide engine for the EX stage.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator; sign fix-up happens in FIXUP.
module pipelined_mdu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic [4:0]      i_rd_in,
  output logic            o_busy,
  output logic            o_result_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_out
);

  localparam int unsigned ITER = XLEN / UNROLL;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam int unsigned PW   = 2 * XLEN;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [2:0]      r_func3;
  logic [XLEN-1:0] r_ma;
  logic [XLEN-1:0] r_mb;
  logic [PW-1:0]   r_acc;
  logic            r_neg;
  logic [4:0]      r_rd;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sa;
  logic            w_sb;
  logic            w_neg;
  logic [XLEN-1:0] w_ma;
  logic [XLEN-1:0] w_mb;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [PW-1:0]   w_acc_step;
  logic [XLEN:0]   w_sum;
  logic [PW-1:0]   w_prod_fix;
  logic [XLEN-1:0] w_div_sel;
  logic [XLEN-1:0] w_div_fix;
  logic [XLEN-1:0] w_fix_res;
  logic            w_busy_d;
  logic            w_valid_d;
  logic [XLEN-1:0] w_result_d;
  logic [4:0]      w_rd_d;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start && !i_flush;

  // Operand signedness, magnitudes and special-case detection at issue time
  always_comb begin
    w_is_div      = i_func3[2];
    w_a_signed    = i_func3[2] ? ~i_func3[0] : (i_func3[1:0] != 2'b11);
    w_b_signed    = i_func3[2] ? ~i_func3[0] : ~i_func3[1];
    w_sa          = w_a_signed & i_operand_a[XLEN-1];
    w_sb          = w_b_signed & i_operand_b[XLEN-1];
    w_ma          = w_sa ? (~i_operand_a + XLEN'(1)) : i_operand_a;
    w_mb          = w_sb ? (~i_operand_b + XLEN'(1)) : i_operand_b;
    w_neg         = (w_is_div & i_func3[1]) ? w_sa : (w_sa ^ w_sb);
    w_div_zero    = ~|i_operand_b;
    w_ovf         = ~i_func3[0] & (i_operand_a == XMIN) & (&i_operand_b);
    w_special     = w_is_div & (w_div_zero | w_ovf);
    w_special_res = i_operand_a;
    if (w_div_zero) begin
      w_special_res = i_func3[1] ? i_operand_a : {XLEN{1'b1}};
    end else if (w_ovf) begin
      w_special_res = i_func3[1] ? {XLEN{1'b0}} : i_operand_a;
    end
  end

  // UNROLL iterations of shift-add (mul) or non-performing restoring step (div)
  always_comb begin
    w_acc_step = r_acc;
    w_sum      = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (r_func3[2]) begin
        w_sum = w_acc_step[PW-1:XLEN-1] - {1'b0, r_mb};
        if (!w_sum[XLEN]) begin
          w_acc_step = {w_sum[XLEN-1:0], w_acc_step[XLEN-2:0], 1'b1};
        end else begin
          w_acc_step = {w_acc_step[PW-2:0], 1'b0};
        end
      end else begin
        w_sum = {1'b0, w_acc_step[PW-1:XLEN]} + (w_acc_step[0] ? {1'b0, r_ma} : {(XLEN+1){1'b0}});
        w_acc_step = {w_sum, w_acc_step[XLEN-1:1]};
      end
    end
  end

  // Sign correction and half / quotient-remainder selection
  always_comb begin
    w_prod_fix = r_neg ? (~r_acc + PW'(1)) : r_acc;
    w_div_sel  = r_func3[1] ? r_acc[PW-1:XLEN] : r_acc[XLEN-1:0];
    w_div_fix  = r_neg ? (~w_div_sel + XLEN'(1)) : w_div_sel;
    if (r_func3[2]) begin
      w_fix_res = w_div_fix;
    end else if (r_func3[1:0] == 2'b00) begin
      w_fix_res = w_prod_fix[XLEN-1:0];
    end else begin
      w_fix_res = w_prod_fix[PW-1:XLEN];
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_next_state = w_special ? S_DONE : S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CALC: begin
        if (i_flush) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_next_state = S_FIXUP;
        end
      end
      S_FIXUP: begin
        w_next_state = i_flush ? S_IDLE : S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_busy_d   = (w_next_state == S_CALC) || (w_next_state == S_FIXUP);
    w_valid_d  = (w_next_state == S_DONE);
    w_result_d = o_result;
    w_rd_d     = o_rd_out;
    if (w_accept && w_special) begin
      w_result_d = w_special_res;
      w_rd_d     = i_rd_in;
    end else if ((r_state == S_FIXUP) && !i_flush) begin
      w_result_d = w_fix_res;
      w_rd_d     = r_rd;
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_func3        <= '0;
      r_ma           <= '0;
      r_mb           <= '0;
      r_acc          <= '0;
      r_neg          <= 1'b0;
      r_rd           <= '0;
      r_cnt          <= '0;
      o_busy         <= 1'b0;
      o_result_valid <= 1'b0;
      o_result       <= '0;
      o_rd_out       <= '0;
    end else begin
      if (w_accept) begin
        r_func3 <= i_func3;
        r_ma    <= w_ma;
        r_mb    <= w_mb;
        r_neg   <= w_neg;
        r_rd    <= i_rd_in;
        r_acc   <= w_is_div ? {XLEN'(0), w_ma} : {XLEN'(0), w_mb};
        r_cnt   <= CW'(ITER);
      end else if (r_state == S_CALC) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt - CW'(1);
      end
      o_busy         <= w_busy_d;
      o_result_valid <= w_valid_d;
      o_result       <= w_result_d;
      o_rd_out       <= w_rd_d;
    end
  end

endmodule

// File: tb/tb_pipelined_mdu.sv
// Directed bench for pipelined_mdu: default build plus UNROLL=4 and XLEN=16/UNROLL=2 builds.
module tb_pipelined_mdu;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  func3;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd;

  logic        busy, valid;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        busy4, valid4;
  logic [31:0] result4;
  logic [4:0]  rd4;
  logic        busy16, valid16;
  logic [15:0] result16;
  logic [4:0]  rd16;

  int checks   = 0;
  int failures = 0;

  pipelined_mdu #(.XLEN(32), .UNROLL(1)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_flush(flush), .i_func3(func3),
    .i_operand_a(a), .i_operand_b(b), .i_rd_in(rd),
    .o_busy(busy), .o_result_valid(valid), .o_result(result), .o_rd_out(rd_out));

  pipelined_mdu #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_flush(flush), .i_func3(func3),
    .i_operand_a(a), .i_operand_b(b), .i_rd_in(rd),
    .o_busy(busy4), .o_result_valid(valid4), .o_result(result4), .o_rd_out(rd4));

  pipelined_mdu #(.XLEN(16), .UNROLL(2)) u_dut16 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_flush(flush), .i_func3(func3),
    .i_operand_a(a[15:0]), .i_operand_b(b[15:0]), .i_rd_in(rd),
    .o_busy(busy16), .o_result_valid(valid16), .o_result(result16), .o_rd_out(rd16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] r);
    @(negedge clk);
    func3 = f; a = av; b = bv; rd = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // n counts samples taken 1 time unit after each edge; sample 1 follows the accept edge
  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic count_valids(input int cycles, output int vc);
    vc = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (valid === 1'b1) vc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] r,
                        input logic [31:0] exp, input int lat);
    int n;
    issue(f, av, bv, r);
    wait_valid(1, n);
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".res"}, result, exp);
    chk({tag, ".rd"}, 32'(rd_out), 32'(r));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 32'(valid), 32'd0);
  endtask

  // Issue to all three builds and capture each one's first valid
  task automatic run_par(input string tag, input logic [2:0] f, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp32,
                         input logic [15:0] exp16);
    int n, nm, n4, n16;
    logic [31:0] rm, r4;
    logic [15:0] r16;
    logic [4:0]  t4, t16;
    nm = 0; n4 = 0; n16 = 0; rm = '0; r4 = '0; r16 = '0; t4 = '0; t16 = '0;
    issue(f, av, bv, 5'd11);
    n = 1;
    while (n <= 40) begin
      if (valid === 1'b1 && nm == 0) begin nm = n; rm = result; end
      if (valid4 === 1'b1 && n4 == 0) begin n4 = n; r4 = result4; t4 = rd4; end
      if (valid16 === 1'b1 && n16 == 0) begin n16 = n; r16 = result16; t16 = rd16; end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".u1.lat"}, 32'(nm), 32'd34);
    chk({tag, ".u1.res"}, rm, exp32);
    chk({tag, ".u4.lat"}, 32'(n4), 32'd10);
    chk({tag, ".u4.res"}, r4, exp32);
    chk({tag, ".u4.rd"}, 32'(t4), 32'd11);
    chk({tag, ".x16.lat"}, 32'(n16), 32'd10);
    chk({tag, ".x16.res"}, 32'(r16), 32'(exp16));
    chk({tag, ".x16.rd"}, 32'(t16), 32'd11);
  endtask

  initial begin
    int n, vc;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; func3 = '0; a = '0; b = '0; rd = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.valid", 32'(valid), 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.rd", 32'(rd_out), 32'd0);

    run_op("mul", F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 34);
    run_op("mulhu", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 34);
    run_op("mulhsu", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 34);
    run_op("mulh", F_MULH, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000, 34);
    run_op("div", F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 34);
    run_op("rem", F_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 34);
    run_op("rem_negdiv", F_REM, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'd1, 34);
    run_op("divu", F_DIVU, 32'd100, 32'd7, 5'd12, 32'd14, 34);
    run_op("remu", F_REMU, 32'd100, 32'd7, 5'd13, 32'd2, 34);

    run_op("divu_by0", F_DIVU, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
    run_op("rem_by0", F_REM, 32'd5, 32'd0, 5'd15, 32'd5, 1);
    run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);

    // Flush mid-CALC: no result, outputs hold the previous op's values
    issue(F_MUL, 32'd3, 32'd4, 5'd9);
    repeat (8) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush.busy", 32'(busy), 32'd0);
    chk("flush.valid", 32'(valid), 32'd0);
    count_valids(40, vc);
    chk("flush.novalid", 32'(vc), 32'd0);
    chk("flush.result", result, 32'h8000_0000);
    chk("flush.rd", 32'(rd_out), 32'd17);

    // START with FLUSH in IDLE is dropped
    @(negedge clk);
    func3 = F_MUL; a = 32'd5; b = 32'd5; rd = 5'd20; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("startflush.busy", 32'(busy), 32'd0);
    count_valids(40, vc);
    chk("startflush.novalid", 32'(vc), 32'd0);
    chk("startflush.rd", 32'(rd_out), 32'd17);

    // Reset mid-divide clears everything and yields no result
    run_op("remu2", F_REMU, 32'd100, 32'd7, 5'd3, 32'd2, 34);
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4);
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.valid", 32'(valid), 32'd0);
    chk("midrst.result", result, 32'd0);
    chk("midrst.rd", 32'(rd_out), 32'd0);
    rst_n = 1'b1;
    count_valids(40, vc);
    chk("midrst.novalid", 32'(vc), 32'd0);

    // Back-to-back issue from DONE, with a START while busy that must be ignored
    issue(F_MUL, 32'd6, 32'd7, 5'd1);
    wait_valid(1, n);
    chk("b2b.first.lat", 32'(n), 32'd34);
    chk("b2b.first.res", result, 32'd42);
    chk("b2b.first.rd", 32'(rd_out), 32'd1);
    func3 = F_REMU; a = 32'd100; b = 32'd7; rd = 5'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.valid", 32'(valid), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    func3 = F_MUL; a = 32'd1; b = 32'd1; rd = 5'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(6, n);
    chk("b2b.second.lat", 32'(n), 32'd34);
    chk("b2b.second.res", result, 32'd2);
    chk("b2b.second.rd", 32'(rd_out), 32'd2);
    count_valids(40, vc);
    chk("b2b.ignored", 32'(vc), 32'd0);

    // FLUSH in DONE: valid already pulsing, concurrent START dropped
    issue(F_DIVU, 32'd5, 32'd0, 5'd6);
    wait_valid(1, n);
    chk("flushdone.lat", 32'(n), 32'd1);
    func3 = F_MUL; a = 32'd2; b = 32'd2; rd = 5'd8; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("flushdone.valid", 32'(valid), 32'd0);
    chk("flushdone.busy", 32'(busy), 32'd0);
    count_valids(40, vc);
    chk("flushdone.novalid", 32'(vc), 32'd0);
    chk("flushdone.result", result, 32'hFFFF_FFFF);
    chk("flushdone.rd", 32'(rd_out), 32'd6);

    // Parameter variants: UNROLL=4 and XLEN=16/UNROLL=2 both take 10 cycles
    run_par("par.div", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 16'hFFFD);
    run_par("par.mulhu", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 16'hFFFE);
    run_par("par.mul", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 16'hFFEB);
    chk("par.idle4", 32'(busy4), 32'd0);
    chk("par.idle16", 32'(busy16), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
